syrk_out_wrapper: RTL and testbench
===================================

// Module: syrk_out_wrapper
// PURPOSE
//  Output-collection stage of the syrk (io_p8) kernel build: accepts the kernel's 8 parallel 32-bit
//  C_out result streams, buffers them per lane and serializes them onto a narrow 4-bit pin bus.
//  Sits between the HLS kernel's C_out_0..7 FIFO write interfaces and the board pins.
//  probe_out gives a running parity of all accepted data, so that no logic is pruned.
// PARAMETERS
//  LANES      8   number of C_out streams (fixed at 8 for this build)
//  DW         32  width of each C_out word
//  FIFO_DEPTH 2   entries per lane buffer
// PORTS
//  ap_clk          in   1     single clock; every register is clocked on its rising edge
//  ap_rst_n        in   1     reset, asynchronous, active-low
//  C_out_k_din     in   32    k=0..7; result word from kernel lane k
//  C_out_k_write   in   1     k=0..7; write strobe for lane k
//  C_out_k_full_n  out  1     k=0..7; lane k buffer can accept a word
//  data_out        out  4     serialized nibble
//  data_valid      out  1     data_out carries a frame nibble this cycle
//  probe_out       out  1     running XOR of all bits of all accepted words
// BEHAVIOUR
//  Reset (ap_rst_n=0, async)
//   - All FIFOs empty; all full_n=1; data_out=0; data_valid=0; probe_out=0.
//   - Serializer goes to IDLE and the round-robin pointer is set to lane 7, so lane 0 has first priority.
//   - Asserting reset mid-frame aborts the frame immediately and discards all buffered words.
//  Accept
//   - Lane k accepts din on a rising edge when C_out_k_write=1 and full_n=1.
//   - A write while full_n=0 is ignored and the word is dropped; the kernel must honour full_n.
//   - full_n is registered and equals (count<FIFO_DEPTH); there is no same-cycle bypass on a pop.
//   - probe_out <= probe_out ^ (^din) for every accepted word.
//   - Simultaneous accepts on several lanes fold all their parities into probe_out on the same edge.
//  Arbitration
//   - Pick the first non-empty lane searching upward from (last_grant+1) mod 8.
//   - The grant pops that lane's FIFO on the edge it is made.
//   - A grant is made only in IDLE or on the edge that ends data nibble 7 (back-to-back, no gap).
//   - A push and a pop on the same lane in the same cycle are both performed; count is unchanged.
//  Frame (9 cycles, data_valid=1 throughout)
//   - HDR cycle: data_out = {1'b0, lane[2:0]}.
//   - DATA0..DATA7 cycles: data_out = word[4i+3:4i], LS nibble first.
//   - After DATA7, go to HDR if any lane is non-empty; otherwise go to IDLE with data_valid=0 and data_out=0.
//  States: IDLE -> HDR -> DATA(cnt 0..7) -> HDR | IDLE.
//  Latency
//   - Word written at edge t into an empty lane while the serializer is IDLE: grant at edge t+1,
//     HDR visible after t+1, DATA0 after t+2, frame ends after edge t+10.
//  All outputs are registered.
// TESTING
//  1. Reset: hold ap_rst_n=0 -> all full_n=1, data_valid=0, data_out=0, probe_out=0.
//     Release mid-frame -> output idles.
//  2. Single word: lane 3 writes 0x12345678 ->
//     data_valid for 9 cycles, data_out = 3,8,7,6,5,4,3,2,1; probe_out=1.
//  3. Round robin: lanes 0,1,7 each write 1 word in the same cycle ->
//     frames in order lanes 0,1,7, back-to-back with no idle cycle (27 valid cycles).
//  4. Backpressure: lane 5 writes 3 consecutive cycles while another frame is in progress ->
//     full_n low after 2 accepts; 3rd word dropped; exactly 2 lane-5 frames emitted.
//  5. Parity: lane 0 writes 0xFFFFFFFF then 0x00000001 ->
//     probe_out stays 0 after the 1st word, becomes 1 after the 2nd.
//  6. Stress: random writes on all lanes honouring full_n ->
//     every accepted word is emitted exactly once, in per-lane order, with the correct lane header.

Source files
------------

// File: rtl/syrk_out_wrapper.sv
// syrk_out_wrapper: collects the kernel's 8 C_out result streams into 2-deep
// per-lane buffers, picks lanes round-robin and serialises each word as a
// 9-nibble frame (lane header, then 8 data nibbles, LS nibble first).
// probe_out keeps a running parity of every accepted word.
module syrk_out_wrapper #(
    parameter int LANES      = 8,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic [DW-1:0] C_out_0_din,
    input  logic          C_out_0_write,
    output logic          C_out_0_full_n,
    input  logic [DW-1:0] C_out_1_din,
    input  logic          C_out_1_write,
    output logic          C_out_1_full_n,
    input  logic [DW-1:0] C_out_2_din,
    input  logic          C_out_2_write,
    output logic          C_out_2_full_n,
    input  logic [DW-1:0] C_out_3_din,
    input  logic          C_out_3_write,
    output logic          C_out_3_full_n,
    input  logic [DW-1:0] C_out_4_din,
    input  logic          C_out_4_write,
    output logic          C_out_4_full_n,
    input  logic [DW-1:0] C_out_5_din,
    input  logic          C_out_5_write,
    output logic          C_out_5_full_n,
    input  logic [DW-1:0] C_out_6_din,
    input  logic          C_out_6_write,
    output logic          C_out_6_full_n,
    input  logic [DW-1:0] C_out_7_din,
    input  logic          C_out_7_write,
    output logic          C_out_7_full_n,
    output logic [3:0]    data_out,
    output logic          data_valid,
    output logic          probe_out
);

    localparam int LW      = $clog2(LANES);
    localparam int PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW      = $clog2(FIFO_DEPTH + 1);
    localparam int NIBBLES = DW / 4;
    localparam int NW      = $clog2(NIBBLES);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    logic [DW-1:0]    din_a  [LANES];
    logic [DW-1:0]    head_a [LANES];
    logic [LANES-1:0] wr_v;
    logic [LANES-1:0] pop_v;
    logic [LANES-1:0] nonempty_v;
    logic [LANES-1:0] full_n_v;
    logic [LANES-1:0] acc_par_v;

    assign din_a[0] = C_out_0_din;
    assign din_a[1] = C_out_1_din;
    assign din_a[2] = C_out_2_din;
    assign din_a[3] = C_out_3_din;
    assign din_a[4] = C_out_4_din;
    assign din_a[5] = C_out_5_din;
    assign din_a[6] = C_out_6_din;
    assign din_a[7] = C_out_7_din;
    assign wr_v = {C_out_7_write, C_out_6_write, C_out_5_write, C_out_4_write,
                   C_out_3_write, C_out_2_write, C_out_1_write, C_out_0_write};
    assign C_out_0_full_n = full_n_v[0];
    assign C_out_1_full_n = full_n_v[1];
    assign C_out_2_full_n = full_n_v[2];
    assign C_out_3_full_n = full_n_v[3];
    assign C_out_4_full_n = full_n_v[4];
    assign C_out_5_full_n = full_n_v[5];
    assign C_out_6_full_n = full_n_v[6];
    assign C_out_7_full_n = full_n_v[7];

    // Per-lane buffer: full_n is registered from the next count, so a pop
    // never frees a slot for a write in the same cycle.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DW-1:0] mem_q [FIFO_DEPTH];
        logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [CW-1:0] count_q, count_d;
        logic          full_n_q, full_n_d;
        logic          push;
        logic          pop;

        assign push = wr_v[gi] & full_n_q;
        assign pop  = pop_v[gi];

        // Next pointers, occupancy and registered space flag
        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            full_n_d = (count_d < CW'(FIFO_DEPTH));
        end

        // Buffer control state; reset empties the lane
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                full_n_q <= 1'b1;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                full_n_q <= full_n_d;
            end
        end

        // Word storage; contents are don't-care while count is zero
        always_ff @(posedge ap_clk) begin
            if (push) begin
                mem_q[wr_ptr_q] <= din_a[gi];
            end
        end

        assign head_a[gi]     = mem_q[rd_ptr_q];
        assign nonempty_v[gi] = (count_q != '0);
        assign full_n_v[gi]   = full_n_q;
        assign acc_par_v[gi]  = push & (^din_a[gi]);
    end

    state_t          state_q, state_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   word_q, word_d;
    logic [LW-1:0]   last_q, last_d;
    logic [3:0]      data_out_q, data_out_d;
    logic            data_valid_q, data_valid_d;
    logic            probe_q, probe_d;
    logic            grant_found;
    logic [LW-1:0]   grant_lane;
    logic [LW-1:0]   idx;
    logic            grant_en;
    logic [DW-1:0]   shifted;

    // Round-robin search starting one past the last granted lane
    always_comb begin
        grant_found = 1'b0;
        grant_lane  = last_q;
        idx         = last_q;
        for (int i = 1; i <= LANES; i++) begin
            idx = last_q + LW'(i);
            if (!grant_found && nonempty_v[idx]) begin
                grant_found = 1'b1;
                grant_lane  = idx;
            end
        end
    end

    assign grant_en = grant_found &&
                      ((state_q == S_IDLE) ||
                       ((state_q == S_DATA) && (cnt_q == NW'(NIBBLES - 1))));
    assign pop_v    = grant_en ? (LANES'(1) << grant_lane) : '0;

    // Serializer next state: outputs are computed one cycle ahead and registered
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        last_d       = last_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        shifted      = word_q;
        case (state_q)
            S_HDR: begin
                state_d      = S_DATA;
                cnt_d        = '0;
                data_out_d   = word_q[3:0];
                data_valid_d = 1'b1;
            end
            S_DATA: begin
                if (cnt_q != NW'(NIBBLES - 1)) begin
                    cnt_d        = cnt_q + NW'(1);
                    shifted      = word_q >> {cnt_d, 2'b00};
                    data_out_d   = shifted[3:0];
                    data_valid_d = 1'b1;
                end else if (!grant_en) begin
                    state_d      = S_IDLE;
                    data_out_d   = 4'h0;
                    data_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
        if (grant_en) begin
            state_d      = S_HDR;
            word_d       = head_a[grant_lane];
            last_d       = grant_lane;
            data_out_d   = 4'(grant_lane);
            data_valid_d = 1'b1;
        end
        probe_d = probe_q ^ (^acc_par_v);
    end

    // Serializer and parity registers; reset aborts any frame in flight
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            word_q       <= '0;
            last_q       <= LW'(LANES - 1);
            data_out_q   <= 4'h0;
            data_valid_q <= 1'b0;
            probe_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            last_q       <= last_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            probe_q      <= probe_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign probe_out  = probe_q;

endmodule

// File: tb/tb_syrk_out_wrapper.sv
// Bench for syrk_out_wrapper: constant vector table for the single-word,
// parity and overflow cases, hand sequences for round robin, backpressure
// and mid-frame reset, and a random run against a queue-based model.
module tb_syrk_out_wrapper;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b1;
    logic [31:0] din_arr [8];
    logic [7:0]  wr_vec = 8'h00;
    logic        full_n_arr [8];
    logic [3:0]  data_out;
    logic        data_valid;
    logic        probe_out;

    always #5 ap_clk = ~ap_clk;

    syrk_out_wrapper dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .C_out_0_din(din_arr[0]), .C_out_0_write(wr_vec[0]), .C_out_0_full_n(full_n_arr[0]),
        .C_out_1_din(din_arr[1]), .C_out_1_write(wr_vec[1]), .C_out_1_full_n(full_n_arr[1]),
        .C_out_2_din(din_arr[2]), .C_out_2_write(wr_vec[2]), .C_out_2_full_n(full_n_arr[2]),
        .C_out_3_din(din_arr[3]), .C_out_3_write(wr_vec[3]), .C_out_3_full_n(full_n_arr[3]),
        .C_out_4_din(din_arr[4]), .C_out_4_write(wr_vec[4]), .C_out_4_full_n(full_n_arr[4]),
        .C_out_5_din(din_arr[5]), .C_out_5_write(wr_vec[5]), .C_out_5_full_n(full_n_arr[5]),
        .C_out_6_din(din_arr[6]), .C_out_6_write(wr_vec[6]), .C_out_6_full_n(full_n_arr[6]),
        .C_out_7_din(din_arr[7]), .C_out_7_write(wr_vec[7]), .C_out_7_full_n(full_n_arr[7]),
        .data_out(data_out), .data_valid(data_valid), .probe_out(probe_out)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: per-lane word queues plus frame position
    typedef logic [31:0] wq_t[$];
    wq_t         mq [8];
    int          m_last;
    int          m_pos;
    logic [31:0] m_word;
    logic        m_probe;
    int          m_accepted;
    logic        e_valid;
    logic [3:0]  e_data;
    logic [7:0]  e_full;
    int          fpos;
    int          hdr_log[$];

    typedef struct {
        bit          rst;
        logic [7:0]  wr;
        logic [31:0] din;
        logic        ev;
        logic [3:0]  ed;
        logic        ep;
        logic [7:0]  ef;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit rst, logic [7:0] wr, logic [31:0] din,
                                logic ev, logic [3:0] ed, logic ep, logic [7:0] ef);
        vec_t v;
        v.rst = rst; v.wr = wr; v.din = din; v.ev = ev; v.ed = ed; v.ep = ep; v.ef = ef;
        return v;
    endfunction

    function automatic logic [7:0] full_vec();
        logic [7:0] f;
        for (int k = 0; k < 8; k++) f[k] = full_n_arr[k];
        return f;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) mq[k].delete();
        m_last = 7; m_pos = -1; m_probe = 1'b0; m_accepted = 0;
        e_valid = 1'b0; e_data = 4'h0; e_full = 8'hFF;
        fpos = -1; hdr_log.delete();
    endtask

    // One clock edge of the model, using the inputs currently driven
    task automatic model_step();
        int sz [8];
        bit found;
        for (int k = 0; k < 8; k++) sz[k] = mq[k].size();
        if (m_pos == -1 || m_pos == 8) begin
            found = 0; m_pos = -1; e_valid = 1'b0; e_data = 4'h0;
            for (int i = 1; i <= 8; i++) begin
                int l;
                l = (m_last + i) % 8;
                if (!found && mq[l].size() > 0) begin
                    found = 1; m_word = mq[l].pop_front(); m_last = l; m_pos = 0;
                    e_valid = 1'b1; e_data = 4'(l);
                end
            end
        end else begin
            m_pos++;
            e_valid = 1'b1;
            e_data  = m_word[4*(m_pos-1) +: 4];
        end
        for (int k = 0; k < 8; k++) begin
            if (wr_vec[k] && sz[k] < 2) begin
                mq[k].push_back(din_arr[k]);
                m_probe = m_probe ^ (^din_arr[k]);
                m_accepted++;
            end
        end
        for (int k = 0; k < 8; k++) e_full[k] = (mq[k].size() < 2);
    endtask

    task automatic check_all(string tag);
        chk({tag, " valid"}, 32'(data_valid), 32'(e_valid));
        chk({tag, " data"},  32'(data_out),   32'(e_data));
        chk({tag, " probe"}, 32'(probe_out),  32'(m_probe));
        chk({tag, " full_n"}, 32'(full_vec()), 32'(e_full));
    endtask

    task automatic track();
        if (data_valid === 1'b1) begin
            if (fpos == -1 || fpos == 8) begin
                hdr_log.push_back(int'(data_out));
                fpos = 0;
            end else begin
                fpos++;
            end
        end else begin
            fpos = -1;
        end
    endtask

    task automatic cycle(string tag);
        model_step();
        @(posedge ap_clk);
        #1;
        wr_vec = 8'h00;
        check_all(tag);
        track();
    endtask

    task automatic do_reset(string tag);
        ap_rst_n = 1'b0;
        wr_vec   = 8'h00;
        model_reset();
        #2;
        check_all({tag, " async"});
        @(posedge ap_clk);
        #1;
        check_all(tag);
        ap_rst_n = 1'b1;
    endtask

    initial begin
        int vcnt;
        int n5;
        for (int k = 0; k < 8; k++) din_arr[k] = 32'h0;
        #1;

        // Parity: 0xFFFFFFFF then 0x00000001 on lane 0
        tbl.push_back(mk(1, 8'h00, 32'h0,        0, 4'h0, 0, 8'hFF));
        tbl.push_back(mk(0, 8'h01, 32'hFFFFFFFF, 0, 4'h0, 0, 8'hFF));
        tbl.push_back(mk(0, 8'h01, 32'h00000001, 1, 4'h0, 1, 8'hFF));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 8'h00, 32'h0, 1, 4'hF, 1, 8'hFF));
        tbl.push_back(mk(0, 8'h00, 32'h0, 1, 4'h0, 1, 8'hFF));
        tbl.push_back(mk(0, 8'h00, 32'h0, 1, 4'h1, 1, 8'hFF));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 8'h00, 32'h0, 1, 4'h0, 1, 8'hFF));
        tbl.push_back(mk(0, 8'h00, 32'h0, 0, 4'h0, 1, 8'hFF));
        // Single word on lane 3: 3,8,7,6,5,4,3,2,1
        tbl.push_back(mk(1, 8'h00, 32'h0,        0, 4'h0, 0, 8'hFF));
        tbl.push_back(mk(0, 8'h08, 32'h12345678, 0, 4'h0, 1, 8'hFF));
        tbl.push_back(mk(0, 8'h00, 32'h0,        1, 4'h3, 1, 8'hFF));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 8'h00, 32'h0, 1, 4'(8 - i), 1, 8'hFF));
        tbl.push_back(mk(0, 8'h00, 32'h0, 0, 4'h0, 1, 8'hFF));
        // Lane 6 overflow: 4th write while full is dropped
        tbl.push_back(mk(1, 8'h00, 32'h0,        0, 4'h0, 0, 8'hFF));
        tbl.push_back(mk(0, 8'h40, 32'h0000000F, 0, 4'h0, 0, 8'hFF));
        tbl.push_back(mk(0, 8'h40, 32'h00000003, 1, 4'h6, 0, 8'hFF));
        tbl.push_back(mk(0, 8'h40, 32'h00000007, 1, 4'hF, 1, 8'hBF));
        tbl.push_back(mk(0, 8'h40, 32'h00000001, 1, 4'h0, 1, 8'hBF));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 8'h00, 32'h0, 1, 4'h0, 1, 8'hBF));
        tbl.push_back(mk(0, 8'h00, 32'h0, 1, 4'h6, 1, 8'hFF));
        tbl.push_back(mk(0, 8'h00, 32'h0, 1, 4'h3, 1, 8'hFF));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 8'h00, 32'h0, 1, 4'h0, 1, 8'hFF));
        tbl.push_back(mk(0, 8'h00, 32'h0, 1, 4'h6, 1, 8'hFF));
        tbl.push_back(mk(0, 8'h00, 32'h0, 1, 4'h7, 1, 8'hFF));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 8'h00, 32'h0, 1, 4'h0, 1, 8'hFF));
        tbl.push_back(mk(0, 8'h00, 32'h0, 0, 4'h0, 1, 8'hFF));

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t  v;
            string tag;
            v   = tbl[i];
            tag = $sformatf("vec%0d", i);
            if (v.rst) begin
                do_reset(tag);
            end else begin
                for (int k = 0; k < 8; k++) if (v.wr[k]) din_arr[k] = v.din;
                wr_vec = v.wr;
                cycle(tag);
            end
            chk({tag, " tbl_valid"},  32'(data_valid), 32'(v.ev));
            chk({tag, " tbl_data"},   32'(data_out),   32'(v.ed));
            chk({tag, " tbl_probe"},  32'(probe_out),  32'(v.ep));
            chk({tag, " tbl_full_n"}, 32'(full_vec()), 32'(v.ef));
        end

        // Round robin: lanes 0,1,7 together -> 27 back-to-back valid cycles
        do_reset("rr_rst");
        din_arr[0] = $urandom; din_arr[1] = $urandom; din_arr[7] = $urandom;
        wr_vec = 8'b1000_0011;
        cycle("rr_wr");
        vcnt = 0;
        for (int i = 0; i < 28; i++) begin
            cycle("rr");
            if (data_valid === 1'b1) vcnt++;
        end
        chk("rr valid_cycles", 32'(vcnt), 32'd27);
        chk("rr frames", 32'(hdr_log.size()), 32'd3);
        if (hdr_log.size() == 3) begin
            chk("rr order0", 32'(hdr_log[0]), 32'd0);
            chk("rr order1", 32'(hdr_log[1]), 32'd1);
            chk("rr order2", 32'(hdr_log[2]), 32'd7);
        end

        // Backpressure: lane 5 writes three times during a lane-2 frame
        do_reset("bp_rst");
        din_arr[2] = $urandom; wr_vec = 8'h04;
        cycle("bp_l2");
        cycle("bp");
        cycle("bp");
        for (int i = 0; i < 3; i++) begin
            din_arr[5] = $urandom; wr_vec = 8'h20;
            cycle("bp_l5");
            if (i == 1) chk("bp full_n5_low", 32'(full_n_arr[5]), 32'd0);
        end
        for (int i = 0; i < 40; i++) cycle("bp_drain");
        n5 = 0;
        foreach (hdr_log[j]) if (hdr_log[j] == 5) n5++;
        chk("bp lane5_frames", 32'(n5), 32'd2);

        // Reset mid-frame discards the frame and all buffered words
        do_reset("mid_rst");
        din_arr[4] = $urandom; din_arr[6] = $urandom; wr_vec = 8'h50;
        cycle("mid_wr");
        din_arr[4] = $urandom; wr_vec = 8'h10;
        cycle("mid_wr");
        for (int i = 0; i < 3; i++) cycle("mid");
        do_reset("mid_abort");
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            cycle("mid_idle");
            if (data_valid !== 1'b0) vcnt++;
        end
        chk("mid idle_after_reset", 32'(vcnt), 32'd0);

        // Random traffic honouring full_n, then drain
        do_reset("rnd_rst");
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < 8; k++) begin
                if (e_full[k] && $urandom_range(0, 2) == 0) begin
                    wr_vec[k]  = 1'b1;
                    din_arr[k] = $urandom;
                end
            end
            cycle("rnd");
        end
        for (int c = 0; c < 200; c++) cycle("rnd_drain");
        chk("rnd frames_vs_accepted", 32'(hdr_log.size()), 32'(m_accepted));
        vcnt = 0;
        for (int k = 0; k < 8; k++) vcnt += mq[k].size();
        chk("rnd model_drained", 32'(vcnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
